alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, 16, ALU operand/result width.
REQ-002 Parameter OPW, 3, ALU opcode width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ0, REQ1  input  1 each  request from requester 0 or 1; held until the matching grant.
REQ-006 A0, B0, A1, B1  input  WIDTH each  operands; held stable with the matching REQ.
REQ-007 OP0, OP1  input  OPW each  opcodes; held stable with the matching REQ.
REQ-008 GNT0, GNT1  output  1 each  registered one-cycle grant pulse.
REQ-009 DONE0, DONE1  output  1 each  registered one-cycle result-valid pulse.
REQ-010 R  output  WIDTH  registered result; holds until the next capture.
REQ-011 ALU_A, ALU_B  output  WIDTH each  registered operands driven to the shared combinational ALU.
REQ-012 ALU_OP  output  OPW  registered opcode driven to the shared ALU.
REQ-013 ALU_R  input  WIDTH  shared ALU result, valid in the same cycle as ALU_A, ALU_B and ALU_OP.
REQ-014 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, DONE; encodings come from the shared package.
REQ-016 IDLE with no REQ: stay in IDLE; all pulse outputs low.
REQ-017 IDLE or DONE with at least one REQ: arbitrate, latch the winner's A, B, OP into ALU_A, ALU_B, ALU_OP, and go to EXEC.
REQ-018 EXEC lasts exactly one cycle: the winner's GNTx is high, R <= ALU_R at the closing edge, then go to DONE.
REQ-019 DONE lasts one cycle with the winner's DONEx high and R valid.
REQ-020 Latency: REQ sampled at edge n gives GNT high in cycle n+1 and DONE and R valid in cycle n+2.
REQ-021 Throughput: continuous requests give one operation every 2 cycles, with EXEC and DONE alternating.
REQ-022 Requesters deassert REQ, or present a new operation, in the cycle after GNT; REQ is not sampled during EXEC.
REQ-023 REQ high during DONE is a new request.
REQ-024 Arbitration is round-robin with a 1-bit pointer LAST holding the last granted requester.
REQ-025 With a single request, that requester wins regardless of LAST.
REQ-026 With both requesting, the requester not equal to LAST wins; LAST updates on entry to EXEC.
REQ-027 The block never asserts GNT0 and GNT1 together, or DONE0 and DONE1 together.
REQ-028 Opcodes pass through undecoded; an opcode outside the table is forwarded unchanged, and the block does not flag it.
REQ-029 ALU_A, ALU_B and ALU_OP hold their last values outside EXEC.

Reset
REQ-030 RST asserted forces immediately: state IDLE, LAST=1 (requester 0 wins the first tie), and every output 0.
REQ-031 Reset mid-operation (EXEC or DONE) discards the operation: no DONE pulse, R=0.
REQ-032 After RST deasserts, the first rising edge samples REQ as in IDLE.

Structure
REQ-033 Shared package alu_pkg holds WIDTH and OPW defaults, FSM state encodings, and the ALU opcode constants.
REQ-034 Opcode constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, FFORCE=5 (result = 4'hF concatenated with A[11:0]), SHL=6, PASS=7.
REQ-035 One sub-module, rr_pick: inputs REQ0, REQ1, LAST; outputs a grant-select bit and a valid bit; combinational.
REQ-036 The shared ALU sits outside alu_arbiter; the bench instantiates it and wires it to ALU_A, ALU_B, ALU_OP and ALU_R.

Verification
REQ-037 Single request: REQ0, A0=16'h1234, OP0=FFORCE -> GNT0 at n+1, DONE0 at n+2, R=16'hF234, BUSY high for 2 cycles.
REQ-038 Tie after reset: REQ0 (ADD 0003+0004) and REQ1 (SUB 0010-0001) in the same cycle -> GNT0 and DONE0 with R=0007, then GNT1 and DONE1 with R=000F; the first result appears 2 cycles before the second.
REQ-039 Saturation: both REQ held high for 8 operations -> grants alternate 0,1,0,1..., one every 2 cycles, and GNT0 and GNT1 are never high together.
REQ-040 Reset mid-op: RST pulsed during EXEC of REQ1 XOR -> no DONE1, R=0, BUSY=0 immediately; the next REQ1 is served normally.
REQ-041 Back-to-back single requester: REQ0 re-raised in DONE with PASS A0=16'hBEEF -> EXEC follows DONE directly and R=16'hBEEF.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter slice.
//   - default operand/result width and opcode width
//   - FSM state encoding for the arbiter control path
//   - opcode constants understood by the shared ALU
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned OPW_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FFORCE yields {4'hF, A[11:0]}; SHL shifts A left by B[3:0].
    localparam logic [OPW_DEF-1:0] OP_ADD    = 3'd0;
    localparam logic [OPW_DEF-1:0] OP_SUB    = 3'd1;
    localparam logic [OPW_DEF-1:0] OP_AND    = 3'd2;
    localparam logic [OPW_DEF-1:0] OP_OR     = 3'd3;
    localparam logic [OPW_DEF-1:0] OP_XOR    = 3'd4;
    localparam logic [OPW_DEF-1:0] OP_FFORCE = 3'd5;
    localparam logic [OPW_DEF-1:0] OP_SHL    = 3'd6;
    localparam logic [OPW_DEF-1:0] OP_PASS   = 3'd7;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: two-way round-robin selector (purely combinational).
//   REQ0, REQ1 : pending requests
//   LAST       : requester granted most recently
//   SEL        : winning requester (valid only when VALID is high)
//   VALID      : at least one request pending
module rr_pick (
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST,
    output logic SEL,
    output logic VALID
);

    always_comb begin
        VALID = REQ0 | REQ1;
        // On a tie the requester that was not served last wins;
        // otherwise the lone requester wins whatever LAST says.
        if (REQ0 && REQ1) begin
            SEL = ~LAST;
        end else begin
            SEL = REQ1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//   CLK, RST           : clock, asynchronous active-high reset
//   REQ0/REQ1          : requests, held until the matching grant
//   A0,B0,OP0 / A1,B1,OP1 : operands and opcode of each requester
//   GNT0/GNT1          : one-cycle grant pulse (high during EXEC)
//   DONE0/DONE1        : one-cycle result-valid pulse (high during DONE)
//   R                  : captured ALU result, held until the next capture
//   ALU_A,ALU_B,ALU_OP : registered operands/opcode to the shared ALU
//   ALU_R              : shared ALU result
//   BUSY               : control FSM is not idle
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [OPW-1:0]   OP0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [OPW-1:0]   OP1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [OPW-1:0]   ALU_OP,
    input  logic [WIDTH-1:0] ALU_R,
    output logic             BUSY
);

    state_t state;
    state_t state_nx;

    // LAST doubles as the owner of the operation in flight, because it is
    // updated on entry to EXEC and not touched again until the next accept.
    logic last;
    logic sel;
    logic valid;
    logic accept;
    logic capture;

    rr_pick u_pick (
        .REQ0  (REQ0),
        .REQ1  (REQ1),
        .LAST  (last),
        .SEL   (sel),
        .VALID (valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // REQ is ignored in EXEC; IDLE and DONE both accept a new request.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_nx = ST_EXEC;
                    accept   = 1'b1;
                end
            end
            ST_EXEC: begin
                state_nx = ST_DONE;
                capture  = 1'b1;
            end
            ST_DONE: begin
                if (valid) begin
                    state_nx = ST_EXEC;
                    accept   = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last   <= 1'b1;
            GNT0   <= 1'b0;
            GNT1   <= 1'b0;
            DONE0  <= 1'b0;
            DONE1  <= 1'b0;
            R      <= '0;
            ALU_A  <= '0;
            ALU_B  <= '0;
            ALU_OP <= '0;
        end else begin
            GNT0  <= accept & ~sel;
            GNT1  <= accept & sel;
            DONE0 <= capture & ~last;
            DONE1 <= capture & last;
            if (accept) begin
                last   <= sel;
                ALU_A  <= sel ? A1  : A0;
                ALU_B  <= sel ? B1  : B0;
                ALU_OP <= sel ? OP1 : OP0;
            end
            if (capture) begin
                R <= ALU_R;
            end
        end
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic [15:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic [2:0]  OP0 = '0, OP1 = '0;
    logic        GNT0, GNT1, DONE0, DONE1, BUSY;
    logic [15:0] R, ALU_A, ALU_B, ALU_R;
    logic [2:0]  ALU_OP;

    int npass  = 0;
    int ntotal = 0;

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1),
        .A0(A0), .B0(B0), .OP0(OP0),
        .A1(A1), .B1(B1), .OP1(OP1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .R(R), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP),
        .ALU_R(ALU_R), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0: alu_fn = a + b;
            3'd1: alu_fn = a - b;
            3'd2: alu_fn = a & b;
            3'd3: alu_fn = a | b;
            3'd4: alu_fn = a ^ b;
            3'd5: alu_fn = {4'hF, a[11:0]};
            3'd6: alu_fn = a << b[3:0];
            default: alu_fn = a;
        endcase
    endfunction

    // the shared ALU lives in the bench
    always_comb ALU_R = alu_fn(ALU_A, ALU_B, ALU_OP);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: an operation is granted (EXEC), then completes one
    // cycle later (DONE) with its result; a new operation can be accepted
    // whenever no operation is currently in its grant cycle.
    logic        m_gnt0, m_gnt1, m_done0, m_done1, m_last;
    logic [15:0] m_r, m_a, m_b;
    logic [2:0]  m_op;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_gnt0 = 0; m_gnt1 = 0; m_done0 = 0; m_done1 = 0;
            m_r = 0; m_a = 0; m_b = 0; m_op = 0; m_last = 1;
        end else begin
            logic granted;
            logic who;
            granted = m_gnt0 | m_gnt1;
            m_done0 = m_gnt0;
            m_done1 = m_gnt1;
            if (granted) m_r = alu_fn(m_a, m_b, m_op);
            if (!granted && (REQ0 || REQ1)) begin
                if (REQ0 && REQ1) who = !m_last;
                else              who = REQ1;
                m_gnt0 = !who;
                m_gnt1 = who;
                m_last = who;
                m_a  = who ? A1  : A0;
                m_b  = who ? B1  : B0;
                m_op = who ? OP1 : OP0;
            end else begin
                m_gnt0 = 0;
                m_gnt1 = 0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("gnt0",  GNT0,  m_gnt0);
        chk("gnt1",  GNT1,  m_gnt1);
        chk("done0", DONE0, m_done0);
        chk("done1", DONE1, m_done1);
        chk("r",     R,     m_r);
        chk("alu_a", ALU_A, m_a);
        chk("alu_b", ALU_B, m_b);
        chk("alu_op", ALU_OP, m_op);
        chk("busy",  BUSY,  m_gnt0 | m_gnt1 | m_done0 | m_done1);
        chk("gnt_excl",  GNT0 & GNT1, 0);
        chk("done_excl", DONE0 & DONE1, 0);
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int last_gcyc;
        RST = 1;
        step(); step();
        chk("reset_busy", BUSY, 0);
        chk("reset_r", R, 0);
        RST = 0;
        step();

        // single request, FFORCE
        REQ0 = 1; A0 = 16'h1234; B0 = 16'h0; OP0 = 3'd5;
        step();
        chk("single_gnt0", GNT0, 1);
        chk("single_busy1", BUSY, 1);
        REQ0 = 0;
        step();
        chk("single_done0", DONE0, 1);
        chk("single_r", R, 16'hF234);
        chk("single_busy2", BUSY, 1);
        step();
        chk("single_idle", BUSY, 0);

        // tie directly after reset
        RST = 1; step(); RST = 0; step();
        REQ0 = 1; A0 = 16'h0003; B0 = 16'h0004; OP0 = 3'd0;
        REQ1 = 1; A1 = 16'h0010; B1 = 16'h0001; OP1 = 3'd1;
        step();
        chk("tie_gnt0", GNT0, 1);
        chk("tie_gnt1_low", GNT1, 0);
        REQ0 = 0;
        step();
        chk("tie_done0", DONE0, 1);
        chk("tie_r0", R, 16'h0007);
        step();
        chk("tie_gnt1", GNT1, 1);
        REQ1 = 0;
        step();
        chk("tie_done1", DONE1, 1);
        chk("tie_r1", R, 16'h000F);
        step();

        // saturation: both held for 8 operations
        REQ0 = 1; A0 = $urandom; B0 = $urandom; OP0 = 3'($urandom_range(0, 7));
        REQ1 = 1; A1 = $urandom; B1 = $urandom; OP1 = 3'($urandom_range(0, 7));
        grants = 0;
        last_gcyc = -2;
        for (int c = 0; c < 16; c++) begin
            step();
            if (GNT0 || GNT1) begin
                chk("sat_order", GNT1, grants % 2);
                chk("sat_spacing", c - last_gcyc, 2);
                last_gcyc = c;
                grants++;
                if (GNT0) begin
                    A0 = $urandom; B0 = $urandom; OP0 = 3'($urandom_range(0, 7));
                end else begin
                    A1 = $urandom; B1 = $urandom; OP1 = 3'($urandom_range(0, 7));
                end
            end
        end
        chk("sat_count", grants, 8);
        REQ0 = 0; REQ1 = 0;
        step(); step();

        // reset during EXEC of a requester-1 XOR
        REQ1 = 1; A1 = 16'h00FF; B1 = 16'h0F0F; OP1 = 3'd4;
        step();
        chk("rst_gnt1", GNT1, 1);
        RST = 1;
        #1;
        chk("rst_busy_now", BUSY, 0);
        chk("rst_r_now", R, 0);
        chk("rst_gnt1_now", GNT1, 0);
        REQ1 = 0;
        step();
        chk("rst_no_done1", DONE1, 0);
        RST = 0;
        step();
        chk("rst_no_done1b", DONE1, 0);
        REQ1 = 1;
        step();
        chk("rst_regnt1", GNT1, 1);
        REQ1 = 0;
        step();
        chk("rst_redone1", DONE1, 1);
        chk("rst_rer", R, 16'h0FF0);
        step();

        // back-to-back single requester
        REQ0 = 1; A0 = 16'h0001; B0 = 16'h0001; OP0 = 3'd0;
        step();
        chk("b2b_gnt0", GNT0, 1);
        A0 = 16'hBEEF; B0 = 16'h1111; OP0 = 3'd7;
        step();
        chk("b2b_done0", DONE0, 1);
        chk("b2b_r1", R, 16'h0002);
        step();
        chk("b2b_gnt0b", GNT0, 1);
        chk("b2b_busy", BUSY, 1);
        chk("b2b_done_low", DONE0, 0);
        REQ0 = 0;
        step();
        chk("b2b_done0b", DONE0, 1);
        chk("b2b_r2", R, 16'hBEEF);
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (RST) RST = 0;
            else if ($urandom_range(0, 199) == 0) begin
                RST = 1; REQ0 = 0; REQ1 = 0;
            end
            if (!RST) begin
                if (REQ0 && GNT0) begin
                    if ($urandom_range(0, 1) == 0) REQ0 = 0;
                    else begin
                        A0 = $urandom; B0 = $urandom; OP0 = 3'($urandom_range(0, 7));
                    end
                end else if (!REQ0 && $urandom_range(0, 9) < 3) begin
                    REQ0 = 1; A0 = $urandom; B0 = $urandom; OP0 = 3'($urandom_range(0, 7));
                end
                if (REQ1 && GNT1) begin
                    if ($urandom_range(0, 1) == 0) REQ1 = 0;
                    else begin
                        A1 = $urandom; B1 = $urandom; OP1 = 3'($urandom_range(0, 7));
                    end
                end else if (!REQ1 && $urandom_range(0, 9) < 3) begin
                    REQ1 = 1; A1 = $urandom; B1 = $urandom; OP1 = 3'($urandom_range(0, 7));
                end
            end
            step();
        end
        RST = 0; REQ0 = 0; REQ1 = 0;
        step(); step(); step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
